instr_line_fill: RTL and testbench

//   Fills the 256-entry instruction line buffer consumed by Instruction Fetch.

---
 rtl/spu_if_pkg.sv | 16 +
 rtl/instr_line_fill.sv | 105 ++++++++++
 tb/tb_instr_line_fill.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/spu_if_pkg.sv
// Shared constants and FSM state type for the instruction line-fill path.
package spu_if_pkg;
  localparam logic [31:0] NOP  = 32'h4020_0000;
  localparam logic [31:0] LNOP = 32'h0020_0000;

  localparam int LINE_WORDS = 16;
  localparam int BEAT_WORDS = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RECV  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } fill_state_t;
endpackage

// File: rtl/instr_line_fill.sv
// Fetches one 64B line from local store (4 x 128-bit beats) into a 16-entry slot of the IF buffer.
// Request held until accepted; fill_done one cycle after the last beat; flush aborts and drains.
module instr_line_fill #(
  parameter int LS_ADDR_W = 18,
  parameter int BUF_DEPTH = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fill_req,
  input  logic [LS_ADDR_W-1:0] fill_ls_addr,
  input  logic [3:0]           fill_slot,
  input  logic                 flush,
  output logic                 ls_req_valid,
  input  logic                 ls_req_ready,
  output logic [LS_ADDR_W-1:0] ls_req_addr,
  input  logic                 ls_rdata_valid,
  input  logic [0:127]         ls_rdata,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic [0:31]          instruction_cache [0:BUF_DEPTH-1]
);
  import spu_if_pkg::*;

  localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS / BEAT_WORDS - 1);

  fill_state_t          r_state;
  logic [1:0]           r_beat_cnt;
  logic [LS_ADDR_W-1:0] r_addr;
  logic [3:0]           r_slot;
  logic [0:31]          r_buf [0:BUF_DEPTH-1];

  logic w_wr;
  logic w_last;
  logic w_unused_lsb;

  assign w_unused_lsb = ^fill_ls_addr[5:0];
  assign w_last       = (r_beat_cnt == LAST_BEAT);
  // A beat landing in the flush cycle belongs to the aborted line and is not written.
  assign w_wr         = (r_state == S_RECV) && ls_rdata_valid && !flush;

  assign ls_req_valid = (r_state == S_REQ);
  assign ls_req_addr  = r_addr;
  assign fill_busy    = (r_state != S_IDLE);
  assign fill_done    = (r_state == S_DONE);
  assign instruction_cache = r_buf;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= 2'd0;
      r_addr     <= '0;
      r_slot     <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fill_req && !flush) begin
            r_addr  <= {fill_ls_addr[LS_ADDR_W-1:6], 6'b0};
            r_slot  <= fill_slot;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (ls_req_ready) begin
            r_beat_cnt <= 2'd0;
            r_state    <= S_RECV;
          end
        end
        S_RECV: begin
          // The beat counter keeps counting through DRAIN so the abort ends on the 4th beat.
          if (flush) begin
            if (ls_rdata_valid) begin
              r_beat_cnt <= r_beat_cnt + 2'd1;
              r_state    <= w_last ? S_IDLE : S_DRAIN;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (ls_rdata_valid) begin
            r_beat_cnt <= r_beat_cnt + 2'd1;
            if (w_last) r_state <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (ls_rdata_valid) begin
            r_beat_cnt <= r_beat_cnt + 2'd1;
            if (w_last) r_state <= S_IDLE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Index {slot, beat, k} is 8 bits wide, so a fill never wraps past the buffer end.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= LNOP;
    end else if (w_wr) begin
      for (int k = 0; k < BEAT_WORDS; k++)
        r_buf[{r_slot, r_beat_cnt, 2'(k)}] <= ls_rdata[32*k +: 32];
    end
  end
endmodule

// File: tb/tb_instr_line_fill.sv
// Scoreboard bench for instr_line_fill: directed fills, flush/reset aborts, timing of fill_done.
module tb_instr_line_fill;
  localparam logic [31:0] LNOP_W = 32'h0020_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        fill_req;
  logic [17:0] fill_ls_addr;
  logic [3:0]  fill_slot;
  logic        flush;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [17:0] ls_req_addr;
  logic        ls_rdata_valid;
  logic [0:127] ls_rdata;
  logic        fill_busy;
  logic        fill_done;
  logic [0:31] icache [0:255];

  instr_line_fill #(.LS_ADDR_W(18), .BUF_DEPTH(256)) dut (
    .clock(clock), .reset(reset), .fill_req(fill_req), .fill_ls_addr(fill_ls_addr),
    .fill_slot(fill_slot), .flush(flush), .ls_req_valid(ls_req_valid),
    .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_rdata_valid(ls_rdata_valid), .ls_rdata(ls_rdata), .fill_busy(fill_busy),
    .fill_done(fill_done), .instruction_cache(icache)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_addr [$];
  int          exp_done [$];
  logic [31:0] exp_buf  [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_buf(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 256; i++)
      if (icache[i] !== exp_buf[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d entries wrong, first idx %0d got %h expected %h",
               name, bad, first, icache[first], exp_buf[first]);
    end
  endtask

  // Monitor: pops expected request addresses and fill_done cycles as the DUT presents them.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (ls_req_valid === 1'b1) begin
        if (exp_addr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: got addr %h, expected no request", ls_req_addr);
        end else begin
          check("req_addr", 32'(ls_req_addr), 32'(exp_addr[0]));
          if (ls_req_ready === 1'b1) void'(exp_addr.pop_front());
        end
      end
      if (fill_done === 1'b1) begin
        if (exp_done.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got fill_done at cycle %0d, expected none", cyc);
        end else begin
          int e;
          e = exp_done.pop_front();
          check("done_cycle", 32'(cyc), 32'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_fill(input logic [17:0] a, input logic [3:0] s);
    fill_req = 1'b1; fill_ls_addr = a; fill_slot = s;
    exp_addr.push_back({a[17:6], 6'b0});
    tick();
    fill_req = 1'b0;
  endtask

  task automatic accept(input int wait_cycles);
    repeat (wait_cycles) tick();
    ls_req_ready = 1'b1;
    tick();
    ls_req_ready = 1'b0;
  endtask

  task automatic beat(input logic [3:0] s, input int b, input logic [31:0] base,
                      input bit wr, input bit push_done);
    logic [31:0] w [4];
    for (int k = 0; k < 4; k++) begin
      w[k] = base + 32'(b * 4 + k);
      if (wr) exp_buf[int'(s) * 16 + b * 4 + k] = w[k];
    end
    ls_rdata = {w[0], w[1], w[2], w[3]};
    ls_rdata_valid = 1'b1;
    if (push_done) exp_done.push_back(cyc + 1);
    tick();
    ls_rdata_valid = 1'b0;
    ls_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b0; fill_req = 1'b0; fill_ls_addr = '0; fill_slot = '0; flush = 1'b0;
    ls_req_ready = 1'b0; ls_rdata_valid = 1'b0; ls_rdata = '0;
    for (int i = 0; i < 256; i++) exp_buf[i] = LNOP_W;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Reset state
    check("rst_busy", 32'(fill_busy), 32'd0);
    check("rst_done", 32'(fill_done), 32'd0);
    check("rst_req_valid", 32'(ls_req_valid), 32'd0);
    check("rst_req_addr", 32'(ls_req_addr), 32'd0);
    check_buf("rst_buf");

    // Back-to-back fill into slot 2, fill_done at accept+5
    start_fill(18'h0_0040, 4'd2);
    check("t2_busy_req", 32'(fill_busy), 32'd1);
    t = cyc;
    accept(0);
    exp_done.push_back(t + 5);
    for (int b = 0; b < 4; b++) beat(4'd2, b, 32'h1000_0000, 1'b1, 1'b0);
    repeat (3) tick();
    check_buf("t2_buf");
    check("t2_idle", 32'(fill_busy), 32'd0);

    // Stalled request, gapped beats, top slot, unaligned address
    start_fill(18'h2_3A7F, 4'd15);
    accept(10);
    for (int b = 0; b < 4; b++) begin
      beat(4'd15, b, 32'h2000_0000, 1'b1, b == 3);
      if (b < 3) repeat (2) tick();
    end
    repeat (3) tick();
    check_buf("t3_buf");

    // Flush after two beats: third beat arrives with flush, fourth drained
    start_fill(18'h0_1000, 4'd5);
    accept(0);
    beat(4'd5, 0, 32'h3000_0000, 1'b1, 1'b0);
    beat(4'd5, 1, 32'h3000_0000, 1'b1, 1'b0);
    flush = 1'b1;
    beat(4'd5, 2, 32'h3000_0000, 1'b0, 1'b0);
    flush = 1'b0;
    check("t4_busy_drain", 32'(fill_busy), 32'd1);
    tick();
    beat(4'd5, 3, 32'h3000_0000, 1'b0, 1'b0);
    check("t4_idle", 32'(fill_busy), 32'd0);
    tick();
    check_buf("t4_buf");

    // Flush wins over fill_req in IDLE; fill_req during RECV is ignored
    fill_req = 1'b1; flush = 1'b1; fill_ls_addr = 18'h3_0000; fill_slot = 4'd9;
    tick();
    fill_req = 1'b0; flush = 1'b0;
    check("t5_no_req", 32'(ls_req_valid), 32'd0);
    check("t5_no_busy", 32'(fill_busy), 32'd0);
    tick();
    start_fill(18'h0_0080, 4'd0);
    accept(0);
    beat(4'd0, 0, 32'h4000_0000, 1'b1, 1'b0);
    fill_req = 1'b1; fill_ls_addr = 18'h1_1100; fill_slot = 4'd12;
    beat(4'd0, 1, 32'h4000_0000, 1'b1, 1'b0);
    tick();
    fill_req = 1'b0;
    beat(4'd0, 2, 32'h4000_0000, 1'b1, 1'b0);
    beat(4'd0, 3, 32'h4000_0000, 1'b1, 1'b1);
    repeat (3) tick();
    check_buf("t5_buf");
    check("t5_idle", 32'(fill_busy), 32'd0);

    // Reset mid-RECV: everything back to LNOP, later beats ignored
    start_fill(18'h0_0100, 4'd7);
    accept(0);
    beat(4'd7, 0, 32'h5000_0000, 1'b1, 1'b0);
    reset = 1'b0;
    beat(4'd7, 1, 32'h5000_0000, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) exp_buf[i] = LNOP_W;
    beat(4'd7, 2, 32'h5000_0000, 1'b0, 1'b0);
    beat(4'd7, 3, 32'h5000_0000, 1'b0, 1'b0);
    repeat (2) tick();
    check("t6_busy", 32'(fill_busy), 32'd0);
    check("t6_done", 32'(fill_done), 32'd0);
    check_buf("t6_buf");

    check("req_queue_empty", 32'(exp_addr.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
